nf_ram_loader: RTL and testbench
================================

Name: nf_ram_loader

Overview:
- Program loader that sits directly upstream of the common RAM (word-addressed, one-cycle combinational write port, read data asynchronous).
- Accepts a byte stream (e.g. from the UART receiver) with valid/ready handshake.
- Assembles little-endian 32-bit words and drives the RAM write port.
- Holds the core in reset while loading so RAM is reprogrammed without a bitstream rebuild.

Parameters:
depth, 64, RAM size in 32-bit words; maximum loadable word count
start_addr, 0, word index of first write

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a load session
byte_in  input  8  incoming stream byte
byte_vld  input  1  byte_in valid
byte_rdy  output  1  loader accepts byte this cycle
ram_addr  output  32  RAM word address
ram_we  output  1  RAM write enable
ram_wd  output  32  RAM write data
busy  output  1  session in progress
cpu_hold  output  1  keep core in reset
done  output  1  sticky: last session completed OK
err  output  1  sticky: last session aborted

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter, byte counter, length register cleared.
- Byte transfer occurs on a clk edge with byte_vld && byte_rdy. byte_rdy = 1 only in LEN and DATA.
- Bytes are little-endian: the first byte of each group of 4 goes to bits [7:0].
- IDLE: start -> LEN; clear done, err, byte count and word index; set busy and cpu_hold.
- LEN: collect 4 bytes into N, the word count.
  - After the 4th byte: N == 0 -> DONE; N > depth - start_addr -> ERR; else DATA.
- DATA: collect 4 bytes into a word; 4th byte accepted -> WRITE.
- WRITE: exactly one cycle. ram_we = 1, ram_addr = start_addr + word index, ram_wd = assembled word.
  - All three are decoded from registers, not from byte_in.
  - Word index increments. If index + 1 == N -> DONE, else DATA.
  - byte_rdy = 0 in WRITE, so the maximum throughput is 4 bytes per 5 cycles.
- DONE: one cycle. Set done, clear busy and cpu_hold, then go to IDLE.
- ERR: one cycle. Set err, clear busy and cpu_hold, then go to IDLE. No further writes.
- ram_we is 0 in every state except WRITE. ram_addr and ram_wd hold their last values outside WRITE.
- start while busy: ignored.
- start in the same cycle as DONE or ERR: ignored. A new start is required in IDLE.
- byte_vld while not in LEN or DATA: not accepted; the byte stays pending upstream.
- rst mid-session: return to IDLE with all outputs 0. RAM words already written are retained. A partial word is discarded.
- Word index wraps nowhere: the length check guarantees ram_addr stays at or below start_addr + depth - 1.

Optional Feature:
- Macro: NF_RAM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data word, a CHK state accepts one byte compared against the XOR of all data bytes; length bytes are excluded.
  - Match -> DONE; mismatch -> ERR.
  - Words already written stay in RAM.
  - N == 0 still expects a checksum byte of 0x00.
- When undefined: no CHK state; the last WRITE goes straight to DONE.

Decomposition:
- Package nf_ram_loader_pkg holds:
  - state enum (IDLE, LEN, DATA, WRITE, CHK, DONE, ERR);
  - byte-count width constant (2 bits);
  - length-field width (32).
- One sub-module, nf_byte_packer:
  - 2-bit byte counter plus 32-bit little-endian shift/insert register;
  - ports clk, rst, clr, byte_in, byte_en, word_out, word_full;
  - reused for the length field and the data words.

Test Plan:
1. start, stream 03 00 00 00 then 0x11223344, 0x55667788, 0xDEADBEEF little-endian with byte_vld held high -> three single-cycle ram_we pulses at addr 0, 1, 2 with those words, each 5 cycles apart; then done = 1, busy = 0, cpu_hold = 0.
2. Length 0 -> no ram_we; done = 1 one cycle after the 4th length byte (checksum build: after a 0x00 checksum byte).
3. Length 65 with depth = 64 -> err = 1, zero writes, cpu_hold released.
4. Random byte_vld gaps plus a start pulse mid-session -> data and addresses identical to scenario 1; the extra start has no effect.
5. rst asserted after 6 data bytes of a 2-word load -> word 0 written; outputs 0 next cycle; a new full session then loads correctly from addr 0.
6. With NF_RAM_LOADER_CHECKSUM_EN: 1 word 0x01020304 plus checksum 0x04 -> done = 1; checksum 0x05 -> err = 1 with word 0 still written.

Source files
------------

// File: rtl/nf_ram_loader_pkg.sv
// nf_ram_loader_pkg: shared types and constants for the RAM program loader.
// Optional checksum stage is enabled with the NF_RAM_LOADER_CHECKSUM_EN macro.
package nf_ram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int BCNT_W = 2;
  localparam int LEN_W  = 32;

  // Place a byte into its little-endian lane of a 32-bit word.
  function automatic logic [LEN_W-1:0] le_insert(input logic [LEN_W-1:0] w,
                                                 input logic [7:0]       b,
                                                 input logic [BCNT_W-1:0] lane);
    logic [LEN_W-1:0] r;
    r = w;
    r[8*int'(lane) +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/nf_ram_loader_if.sv
// nf_ram_loader_if: byte stream handshake plus RAM write port of the loader.
// master = the loader itself, slave = byte source / RAM side.
interface nf_ram_loader_if;

  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        byte_rdy;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wd;

  modport master (
    input  byte_in, byte_vld,
    output byte_rdy, ram_addr, ram_we, ram_wd
  );

  modport slave (
    output byte_in, byte_vld,
    input  byte_rdy, ram_addr, ram_we, ram_wd
  );

endinterface

// File: rtl/nf_byte_packer.sv
// nf_byte_packer: gathers four bytes into a little-endian 32-bit word.
// word_full flags the cycle in which the fourth byte is being accepted.
module nf_byte_packer
  import nf_ram_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       byte_in,
  input  logic             byte_en,
  output logic [LEN_W-1:0] word_out,
  output logic             word_full
);

  logic [BCNT_W-1:0] cnt;

  // Insert each accepted byte into its lane and advance the lane counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt      <= '0;
      word_out <= '0;
    end else if (byte_en) begin
      word_out <= le_insert(word_out, byte_in, cnt);
      cnt      <= cnt + 1'b1;
    end
  end

  assign word_full = byte_en && (cnt == BCNT_W'(3));

endmodule

// File: rtl/nf_ram_loader.sv
// nf_ram_loader: loads a length-prefixed little-endian word stream into RAM
// while holding the core in reset.
// Optional: NF_RAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module nf_ram_loader
  import nf_ram_loader_pkg::*;
#(
  parameter int depth      = 64,
  parameter int start_addr = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  nf_ram_loader_if.master    bus,
  output logic               busy,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(depth - start_addr);
  localparam logic [31:0]      BASE      = 32'(start_addr);

  state_t           state, nstate;
  logic             accept;
  logic             pk_clr;
  logic             pk_en;
  logic             pk_full;
  logic [LEN_W-1:0] pk_word;
  logic [LEN_W-1:0] len_now;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] widx;
  logic [31:0]      addr_hold;
  logic [31:0]      wd_hold;
`ifdef NF_RAM_LOADER_CHECKSUM_EN
  logic [7:0]       xsum;
`endif

  assign accept  = bus.byte_vld && bus.byte_rdy;
  assign pk_clr  = (state == IDLE) && start;
  assign pk_en   = accept && ((state == LEN) || (state == DATA));
  assign len_now = {bus.byte_in, pk_word[23:0]};

  nf_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr),
    .byte_in   (bus.byte_in),
    .byte_en   (pk_en),
    .word_out  (pk_word),
    .word_full (pk_full)
  );

  // Session state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Session sequencing: length field, data words, optional checksum, status.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (start) nstate = LEN;
      LEN: begin
        if (pk_full) begin
          if (len_now == '0) begin
`ifdef NF_RAM_LOADER_CHECKSUM_EN
            nstate = CHK;
`else
            nstate = DONE;
`endif
          end else if (len_now > MAX_WORDS) begin
            nstate = ERR;
          end else begin
            nstate = DATA;
          end
        end
      end
      DATA:  if (pk_full) nstate = WRITE;
      WRITE: begin
        if ((widx + LEN_W'(1)) == len_q) begin
`ifdef NF_RAM_LOADER_CHECKSUM_EN
          nstate = CHK;
`else
          nstate = DONE;
`endif
        end else begin
          nstate = DATA;
        end
      end
`ifdef NF_RAM_LOADER_CHECKSUM_EN
      CHK:   if (accept) nstate = (bus.byte_in == xsum) ? DONE : ERR;
`endif
      DONE:  nstate = IDLE;
      ERR:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Handshake and RAM port decode; address/data hold their last write outside WRITE.
  always_comb begin
    bus.byte_rdy = (state == LEN) || (state == DATA);
`ifdef NF_RAM_LOADER_CHECKSUM_EN
    if (state == CHK) bus.byte_rdy = 1'b1;
`endif
    bus.ram_we   = (state == WRITE);
    bus.ram_addr = (state == WRITE) ? (BASE + widx) : addr_hold;
    bus.ram_wd   = (state == WRITE) ? pk_word : wd_hold;
  end

  // Length, word index, checksum and held RAM port values.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      widx      <= '0;
      addr_hold <= '0;
      wd_hold   <= '0;
`ifdef NF_RAM_LOADER_CHECKSUM_EN
      xsum      <= '0;
`endif
    end else begin
      if (pk_clr) begin
        len_q <= '0;
        widx  <= '0;
`ifdef NF_RAM_LOADER_CHECKSUM_EN
        xsum  <= '0;
`endif
      end
      if ((state == LEN) && pk_full) len_q <= len_now;
`ifdef NF_RAM_LOADER_CHECKSUM_EN
      if ((state == DATA) && accept) xsum <= xsum ^ bus.byte_in;
`endif
      if (state == WRITE) begin
        widx      <= widx + LEN_W'(1);
        addr_hold <= BASE + widx;
        wd_hold   <= pk_word;
      end
    end
  end

  // Status flags: busy/cpu_hold for the session, sticky done/err outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
        end
        DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        ERR: begin
          err      <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nf_ram_loader.sv
// tb_nf_ram_loader: randomized self-checking bench for nf_ram_loader.
// Build with NF_RAM_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_nf_ram_loader;

  localparam int DEPTH = 64;
  localparam int START = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, cpu_hold, done, err;

  nf_ram_loader_if bus ();

  nf_ram_loader #(.depth(DEPTH), .start_addr(START)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [7:0]  stream[$];
  logic [31:0] words[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic        exp_done, exp_err;
  logic [31:0] got_addr[$], got_data[$];
  int          got_cyc[$];
  logic        hold_seen;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write mid-cycle, plus whether cpu_hold was ever raised.
  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      got_addr.push_back(bus.ram_addr);
      got_data.push_back(bus.ram_wd);
      got_cyc.push_back(cyc);
    end
    if (cpu_hold === 1'b1) hold_seen = 1'b1;
  end

  // Length prefix, little-endian words, then (checksum build) the XOR byte.
  task automatic build_stream(input logic [31:0] n, input logic [7:0] chk_mask);
    logic [7:0] x;
    x = 8'h00;
    stream.delete();
    for (int b = 0; b < 4; b++) stream.push_back(n[8*b +: 8]);
    foreach (words[i]) begin
      for (int b = 0; b < 4; b++) begin
        stream.push_back(words[i][8*b +: 8]);
        x = x ^ words[i][8*b +: 8];
      end
    end
`ifdef NF_RAM_LOADER_CHECKSUM_EN
    if (n <= 32'(DEPTH - START)) stream.push_back(x ^ chk_mask);
`else
    if (chk_mask != 8'h00) x = 8'h00;
`endif
  endtask

  // Reference model: decode the byte stream into the expected writes and outcome.
  task automatic model_expect();
    logic [31:0] n, w;
    logic [7:0]  x;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    x = 8'h00;
    n = {stream[3], stream[2], stream[1], stream[0]};
    if (n > 32'(DEPTH - START)) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = {stream[4+4*i+3], stream[4+4*i+2], stream[4+4*i+1], stream[4+4*i]};
      exp_addr.push_back(32'(START + i));
      exp_data.push_back(w);
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
`ifdef NF_RAM_LOADER_CHECKSUM_EN
    if (stream[4+4*int'(n)] == x) exp_done = 1'b1;
    else                          exp_err  = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic clear_capture();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    hold_seen = 1'b0;
  endtask

  // Push the stream through the handshake; optional random gaps and a stray start.
  task automatic drive_bytes(input bit gaps, input bit extra_start);
    int idx = 0;
    int budget = 0;
    bit pulsed = 0;
    while (idx < stream.size() && budget < 5000) begin
      @(negedge clk);
      budget++;
      start = 1'b0;
      if (extra_start && !pulsed && idx == 6) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.byte_vld = 1'b0;
      end else begin
        bus.byte_vld = 1'b1;
        bus.byte_in  = stream[idx];
        if (bus.byte_rdy === 1'b1) idx++;
      end
    end
    @(negedge clk);
    bus.byte_vld = 1'b0;
    start = 1'b0;
    if (idx < stream.size()) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drive_timeout: sent %0d bytes, required %0d", idx, stream.size());
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic run_session(input bit gaps, input bit extra_start);
    clear_capture();
    pulse_start();
    drive_bytes(gaps, extra_start);
    wait_idle();
  endtask

  task automatic test_reset();
    tests_run++;
    if ({busy, cpu_hold, done, err, bus.ram_we, bus.byte_rdy} !== 6'b0 ||
        bus.ram_addr !== 32'h0 || bus.ram_wd !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: busy=%b hold=%b done=%b err=%b we=%b rdy=%b addr=%h wd=%h, required all 0",
               busy, cpu_hold, done, err, bus.ram_we, bus.byte_rdy, bus.ram_addr, bus.ram_wd);
    end
  endtask

  task automatic test_basic();
    words = '{32'h11223344, 32'h55667788, 32'hDEADBEEF};
    build_stream(32'd3, 8'h00);
    model_expect();
    run_session(1'b0, 1'b0);
    tests_run++;
    if (got_addr.size() !== 3 || exp_addr.size() !== 3) begin
      tests_failed++;
      $display("[TB] FAIL basic_count: got %0d writes, required 3", got_addr.size());
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      tests_run++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_write%0d: got %h@%h, required %h@%h",
                 i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      end
      if (i > 0) begin
        tests_run++;
        if (got_cyc[i] - got_cyc[i-1] !== 5) begin
          tests_failed++;
          $display("[TB] FAIL basic_spacing%0d: got %0d cycles, required 5", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
    tests_run++;
    if (done !== exp_done || err !== exp_err || cpu_hold !== 1'b0 || hold_seen !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_status: done=%b err=%b hold=%b held=%b, required done=%b err=%b hold=0 held=1",
               done, err, cpu_hold, hold_seen, exp_done, exp_err);
    end
  endtask

  task automatic test_len_zero();
    words.delete();
    build_stream(32'd0, 8'h00);
    model_expect();
    clear_capture();
    pulse_start();
    drive_bytes(1'b0, 1'b0);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL zero_pending: done=%b busy=%b, required done=0 busy=1", done, busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== exp_done || err !== exp_err || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_done: done=%b err=%b busy=%b hold=%b, required done=%b err=%b busy=0 hold=0",
               done, err, busy, cpu_hold, exp_done, exp_err);
    end
    tests_run++;
    if (got_addr.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL zero_writes: got %0d writes, required 0", got_addr.size());
    end
  endtask

  task automatic test_len_overflow();
    words.delete();
    build_stream(32'(DEPTH - START + 1), 8'h00);
    model_expect();
    run_session(1'b0, 1'b0);
    tests_run++;
    if (err !== exp_err || done !== exp_done || cpu_hold !== 1'b0 || got_addr.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL overflow: err=%b done=%b hold=%b writes=%0d, required err=%b done=%b hold=0 writes=0",
               err, done, cpu_hold, got_addr.size(), exp_err, exp_done);
    end
  endtask

  // Randomized sessions (including the full-depth boundary) against the model.
  task automatic test_random_sessions(input int count, input bit full_depth, input bit gaps, input bit extra_start);
    for (int s = 0; s < count; s++) begin
      int n;
      n = full_depth ? (DEPTH - START) : int'($urandom_range(1, 6));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      build_stream(32'(n), 8'h00);
      model_expect();
      run_session(gaps, extra_start);
      tests_run++;
      if (got_addr.size() !== exp_addr.size()) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_count: got %0d writes, required %0d", s, got_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
        tests_run++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          tests_failed++;
          $display("[TB] FAIL rand%0d_write%0d: got %h@%h, required %h@%h",
                   s, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
        end
      end
      tests_run++;
      if (done !== exp_done || err !== exp_err || cpu_hold !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_status: done=%b err=%b hold=%b, required done=%b err=%b hold=0",
                 s, done, err, cpu_hold, exp_done, exp_err);
      end
    end
  endtask

  task automatic test_gaps_start();
    words = '{32'h11223344, 32'h55667788, 32'hDEADBEEF};
    build_stream(32'd3, 8'h00);
    model_expect();
    run_session(1'b1, 1'b1);
    tests_run++;
    if (got_addr.size() !== exp_addr.size()) begin
      tests_failed++;
      $display("[TB] FAIL gaps_count: got %0d writes, required %0d", got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      tests_run++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        tests_failed++;
        $display("[TB] FAIL gaps_write%0d: got %h@%h, required %h@%h",
                 i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      end
    end
    tests_run++;
    if (done !== exp_done || err !== exp_err) begin
      tests_failed++;
      $display("[TB] FAIL gaps_status: done=%b err=%b, required done=%b err=%b", done, err, exp_done, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w0;
    w0 = $urandom;
    words = '{w0, $urandom};
    build_stream(32'd2, 8'h00);
    while (stream.size() > 10) void'(stream.pop_back());
    clear_capture();
    pulse_start();
    drive_bytes(1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, cpu_hold, done, err, bus.ram_we, bus.byte_rdy} !== 6'b0 ||
        bus.ram_addr !== 32'h0 || bus.ram_wd !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_outputs: busy=%b hold=%b done=%b err=%b we=%b rdy=%b addr=%h wd=%h, required all 0",
               busy, cpu_hold, done, err, bus.ram_we, bus.byte_rdy, bus.ram_addr, bus.ram_wd);
    end
    rst = 1'b0;
    tests_run++;
    if (got_addr.size() !== 1 || got_addr[0] !== 32'(START) || got_data[0] !== w0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_word0: got %0d writes (first %h), required 1 write of %h",
               got_addr.size(), (got_data.size() > 0) ? got_data[0] : 32'h0, w0);
    end
    test_random_sessions(1, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef NF_RAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    words = '{32'h01020304};
    build_stream(32'd1, 8'h00);
    model_expect();
    run_session(1'b0, 1'b0);
    tests_run++;
    if (stream[8] !== 8'h04 || done !== 1'b1 || err !== 1'b0 || got_addr.size() !== 1) begin
      tests_failed++;
      $display("[TB] FAIL chk_good: chk=%h done=%b err=%b writes=%0d, required chk=04 done=1 err=0 writes=1",
               stream[8], done, err, got_addr.size());
    end
    build_stream(32'd1, 8'h01);
    model_expect();
    run_session(1'b0, 1'b0);
    tests_run++;
    if (done !== exp_done || err !== 1'b1 || got_addr.size() !== 1 ||
        (got_data.size() > 0 && got_data[0] !== 32'h01020304)) begin
      tests_failed++;
      $display("[TB] FAIL chk_bad: done=%b err=%b writes=%0d, required done=0 err=1 writes=1 of 01020304",
               done, err, got_addr.size());
    end
  endtask
`endif

  initial begin
    bus.byte_in  = 8'h00;
    bus.byte_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_len_zero();
    test_len_overflow();
    test_gaps_start();
    test_reset_mid();
    test_random_sessions(4, 1'b0, 1'b1, 1'b0);
    test_random_sessions(1, 1'b1, 1'b0, 1'b0);
`ifdef NF_RAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
